// File: rtl/zbus_pkg.sv
// zbus_pkg: shared FSM states, window-register layout and Z80 address fields
package zbus_pkg;
    typedef enum logic [1:0] {IDLE, WR, RD, RELEASE} state_t;
    typedef struct packed {
        logic       en;
        logic [1:0] q;
    } win_t;
    localparam int WIN_EN_BIT = 2;
    localparam int WIN_Q_HI = 1;
    localparam int WIN_Q_LO = 0;
    localparam int PAGE_HI = 15;
    localparam int PAGE_LO = 14;
    localparam int IDX_HI = 11;
    localparam int IDX_LO = 8;
    localparam logic [1:0] PAGE_PORT = 2'b10;
    localparam logic [1:0] PAGE_WIN = 2'b11;
    function automatic win_t win_from_byte(input logic [7:0] d);
        return '{en: d[WIN_EN_BIT], q: d[WIN_Q_HI:WIN_Q_LO]};
    endfunction
endpackage

// File: rtl/zbus_ports_if.sv
// zbus_ports_if: Z80 bus strobes/data, user port handshake and window chip selects
interface zbus_ports_if #(
    parameter int NPORTS = 4,
    parameter int NWIN = 2
) ();
    logic [15:0]               za;
    logic [7:0]                zd_in;
    logic [7:0]                zd_out;
    logic                      zd_oe;
    logic                      ziorq_n;
    logic                      zmreq_n;
    logic                      zrd_n;
    logic                      zwr_n;
    logic                      port_wr_stb;
    logic [$clog2(NPORTS)-1:0] port_addr;
    logic [7:0]                port_wrdata;
    logic [7:0]                port_rddata;
    logic [NWIN-1:0]           win_cs_n;
    modport master (
        output za, zd_in, ziorq_n, zmreq_n, zrd_n, zwr_n, port_rddata,
        input  zd_out, zd_oe, port_wr_stb, port_addr, port_wrdata, win_cs_n
    );
    modport slave (
        input  za, zd_in, ziorq_n, zmreq_n, zrd_n, zwr_n, port_rddata,
        output zd_out, zd_oe, port_wr_stb, port_addr, port_wrdata, win_cs_n
    );
endinterface

// File: rtl/zbus_sync.sv
// zbus_sync: 2-FF synchronizer for asynchronous active-low strobes, resets to all ones
module zbus_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    // two-stage capture; idle-high reset value never fakes an active strobe
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    assign q_o = sync_q;
endmodule

// File: rtl/zbus_ports.sv
// zbus_ports: Z80 IO port decoder with user write strobe and memory-window chip selects.
// Define ZBUS_READBACK_EN to let window-register reads return {5'b0, enable, quarter}.
module zbus_ports
    import zbus_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hAB,
    parameter int NPORTS = 4,
    parameter int NWIN = 2
) (
    input  logic        fclk,
    input  logic        rst,
    zbus_ports_if.slave bus,
    output wire         ziorqge,
    output wire         zblkrom
);
    localparam int AW = $clog2(NPORTS);
    localparam int IW = AW > 2 ? AW : 2;
    logic iorq_s, rd_s, wr_s;
    state_t state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [7:0] data_q;
    logic is_port_q;
    win_t win_q [NWIN];
    logic [1:0] warm_q;
    logic armed_q;
    logic start, port_hit, win_hit, rd_hit;
    logic [1:0] widx;
    logic [NWIN-1:0] win_hit_v;

    zbus_sync #(.W(3)) u_sync (
        .clk(fclk),
        .rst(rst),
        .d_i({bus.ziorq_n, bus.zrd_n, bus.zwr_n}),
        .q_o({iorq_s, rd_s, wr_s})
    );

    assign start = armed_q && state_q == IDLE && !iorq_s && (!rd_s || !wr_s);
    assign port_hit = bus.za[7:0] == BASE_ADDR && bus.za[PAGE_HI:PAGE_LO] == PAGE_PORT
                      && 32'(bus.za[IDX_HI:IDX_LO]) < NPORTS;
    assign win_hit = bus.za[7:0] == BASE_ADDR && bus.za[PAGE_HI:PAGE_LO] == PAGE_WIN
                     && 32'(bus.za[IDX_LO+1:IDX_LO]) < NWIN;
`ifdef ZBUS_READBACK_EN
    assign rd_hit = port_hit || win_hit;
`else
    assign rd_hit = port_hit;
`endif
    assign widx = idx_q[1:0];

    // after reset, wait for flushed synchronizers and an idle iorq before accepting cycles
    always_ff @(posedge fclk or posedge rst)
        if (rst) begin
            warm_q <= '0;
            armed_q <= 1'b0;
        end else begin
            warm_q <= warm_q == 2'd3 ? warm_q : warm_q + 2'd1;
            armed_q <= armed_q || (warm_q == 2'd3 && iorq_s);
        end

    // state register
    always_ff @(posedge fclk or posedge rst)
        if (rst) state_q <= IDLE;
        else state_q <= state_d;

    // next state: writes take priority, misses park in RELEASE until iorq goes idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = !wr_s ? ((port_hit || win_hit) ? WR : RELEASE) : (rd_hit ? RD : RELEASE);
            WR: state_d = RELEASE;
            RD: if (rd_s || iorq_s) state_d = RELEASE;
            default: if (iorq_s) state_d = IDLE;
        endcase
    end

    // latch index/data/decode at cycle start; window registers load during WR
    always_ff @(posedge fclk or posedge rst)
        if (rst) begin
            idx_q <= '0;
            data_q <= '0;
            is_port_q <= 1'b0;
            for (int i = 0; i < NWIN; i++) win_q[i] <= '0;
        end else begin
            if (start) begin
                idx_q <= bus.za[IDX_LO +: IW];
                data_q <= bus.zd_in;
                is_port_q <= port_hit;
            end
            if (state_q == WR && !is_port_q)
                for (int i = 0; i < NWIN; i++)
                    if (widx == i[1:0]) win_q[i] <= win_from_byte(data_q);
        end

    // outputs: single write pulse in WR, read drive gated by the raw strobes
    always_comb begin
        bus.port_wr_stb = state_q == WR && is_port_q;
        bus.zd_oe = state_q == RD && !bus.ziorq_n && !bus.zrd_n;
    end

    assign bus.port_addr = idx_q[AW-1:0];
    assign bus.port_wrdata = data_q;

`ifdef ZBUS_READBACK_EN
    win_t rb;
    // select the addressed window register for readback
    always_comb begin
        rb = '0;
        for (int i = 0; i < NWIN; i++)
            if (widx == i[1:0]) rb = win_q[i];
    end
    assign bus.zd_out = is_port_q ? bus.port_rddata : {5'b0, rb};
`else
    assign bus.zd_out = bus.port_rddata;
`endif

    // lowest-index enabled window matching the quarter owns the memory cycle
    always_comb begin
        win_hit_v = '0;
        for (int i = 0; i < NWIN; i++)
            win_hit_v[i] = win_q[i].en && win_q[i].q == bus.za[PAGE_HI:PAGE_LO]
                           && !bus.zmreq_n && (!bus.zwr_n || !bus.zrd_n);
        bus.win_cs_n = '1;
        for (int i = NWIN - 1; i >= 0; i--)
            if (win_hit_v[i]) bus.win_cs_n = ~(NWIN'(1) << i);
    end

    assign ziorqge = bus.za[7:0] == BASE_ADDR ? 1'b1 : 1'bz;
    assign zblkrom = |win_hit_v ? 1'b1 : 1'bz;
endmodule

// File: tb/tb_zbus_ports.sv
// tb_zbus_ports: randomized Z80 IO/memory cycles checked against a behavioural model
module tb_zbus_ports;
    localparam int NP = 4;
    localparam int NW = 2;
    localparam logic [7:0] BASE = 8'hAB;

    logic fclk = 1'b0;
    logic rst = 1'b1;
    wire ziorqge, zblkrom;
    bit live = 1'b0;
    int npass = 0, nchk = 0, cyc = 0;
    int stb_cnt = 0, stb_cyc = 0, fall_cyc = 0;
    logic [1:0] stb_addr;
    logic [7:0] stb_data;
    logic [7:0] user_rd [NP];
    logic [2:0] mwin [NW];

    zbus_ports_if #(.NPORTS(NP), .NWIN(NW)) bus ();
    zbus_ports #(.BASE_ADDR(BASE), .NPORTS(NP), .NWIN(NW)) dut (
        .fclk(fclk), .rst(rst), .bus(bus), .ziorqge(ziorqge), .zblkrom(zblkrom)
    );

    always #5 fclk = ~fclk;
    assign bus.port_rddata = user_rd[bus.port_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit is_port(input logic [15:0] a);
        return a[7:0] == BASE && a[15:14] == 2'b10 && 32'(a[11:8]) < NP;
    endfunction

    function automatic bit is_win(input logic [15:0] a);
        return a[7:0] == BASE && a[15:14] == 2'b11 && 32'(a[9:8]) < NW;
    endfunction

    function automatic logic [2:0] win_of(input logic [1:0] i);
        logic [2:0] w = '0;
        for (int j = 0; j < NW; j++) if (j == 32'(i)) w = mwin[j];
        return w;
    endfunction

    function automatic logic [NW-1:0] model_cs();
        if (!bus.zmreq_n && !(bus.zrd_n && bus.zwr_n))
            for (int i = 0; i < NW; i++)
                if (mwin[i][2] && mwin[i][1:0] == bus.za[15:14]) return ~(NW'(1) << i);
        return '1;
    endfunction

    always @(negedge fclk) begin
        cyc++;
        if (bus.port_wr_stb) begin
            stb_cnt++;
            stb_cyc = cyc;
            stb_addr = bus.port_addr;
            stb_data = bus.port_wrdata;
        end
        if (live && !rst) begin
            chk("win_cs_n", bus.win_cs_n, model_cs());
            chk("zblkrom", zblkrom === 1'b1, model_cs() != '1);
            chk("ziorqge", ziorqge === 1'b1, bus.za[7:0] == BASE);
            if (bus.zrd_n || bus.ziorq_n) chk("zd_oe_idle", bus.zd_oe, 0);
        end
    end

    task automatic gap_edge();
        int off = $urandom_range(1, 8);
        @(posedge fclk);
        #(off >= 5 ? off + 1 : off);
    endtask

    task automatic io_out(input logic [15:0] a, input logic [7:0] d);
        bit ph = is_port(a);
        bit wh = is_win(a);
        bus.za = a;
        bus.zd_in = d;
        stb_cnt = 0;
        gap_edge();
        bus.ziorq_n = 1'b0;
        bus.zwr_n = 1'b0;
        fall_cyc = cyc;
        repeat ($urandom_range(6, 14)) @(negedge fclk);
        gap_edge();
        bus.zwr_n = 1'b1;
        bus.ziorq_n = 1'b1;
        repeat (6) @(negedge fclk);
        chk("stb_count", stb_cnt, ph);
        if (ph) begin
            chk("stb_port_addr", stb_addr, a[9:8]);
            chk("stb_wrdata", stb_data, d);
            chk("stb_latency_ok", (stb_cyc - fall_cyc) inside {[2:4]}, 1);
            chk("port_addr_held", bus.port_addr, a[9:8]);
            chk("port_wrdata_held", bus.port_wrdata, d);
        end
        if (wh)
            for (int i = 0; i < NW; i++) if (i == 32'(a[9:8])) mwin[i] = d[2:0];
    endtask

    task automatic io_in(input logic [15:0] a, output logic seen_oe, output logic [7:0] seen_d);
        bit exp_oe = is_port(a);
        logic [7:0] exp_d = is_port(a) ? user_rd[a[9:8]] : 8'h00;
`ifdef ZBUS_READBACK_EN
        if (is_win(a)) begin
            exp_oe = 1'b1;
            exp_d = {5'b0, win_of(a[9:8])};
        end
`endif
        bus.za = a;
        stb_cnt = 0;
        gap_edge();
        bus.ziorq_n = 1'b0;
        bus.zrd_n = 1'b0;
        repeat ($urandom_range(6, 14)) @(negedge fclk);
        seen_oe = bus.zd_oe;
        seen_d = bus.zd_out;
        chk("rd_oe", seen_oe, exp_oe);
        if (exp_oe) chk("rd_data", seen_d, exp_d);
        gap_edge();
        bus.zrd_n = 1'b1;
        #1;
        chk("rd_oe_release", bus.zd_oe, 0);
        #1;
        bus.ziorq_n = 1'b1;
        repeat (6) @(negedge fclk);
        chk("rd_no_stb", stb_cnt, 0);
    endtask

    task automatic mem(input logic [15:0] a, input bit wr, output logic [NW-1:0] cs, output logic blk);
        bus.za = a;
        stb_cnt = 0;
        gap_edge();
        bus.zmreq_n = 1'b0;
        if (wr) bus.zwr_n = 1'b0;
        else bus.zrd_n = 1'b0;
        repeat ($urandom_range(2, 5)) @(negedge fclk);
        cs = bus.win_cs_n;
        blk = zblkrom === 1'b1;
        gap_edge();
        bus.zmreq_n = 1'b1;
        bus.zwr_n = 1'b1;
        bus.zrd_n = 1'b1;
        repeat (4) @(negedge fclk);
        chk("mem_no_stb", stb_cnt, 0);
    endtask

    task automatic m1_cycle();
        bus.za = 16'h82AB;
        stb_cnt = 0;
        gap_edge();
        bus.ziorq_n = 1'b0;
        repeat (6) @(negedge fclk);
        chk("m1_oe", bus.zd_oe, 0);
        gap_edge();
        bus.ziorq_n = 1'b1;
        repeat (4) @(negedge fclk);
        chk("m1_no_stb", stb_cnt, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic oe, blk;
        logic [7:0] d;
        logic [NW-1:0] cs;
        logic [15:0] a;
        int k;
        bus.za = '0;
        bus.zd_in = '0;
        bus.ziorq_n = 1'b1;
        bus.zmreq_n = 1'b1;
        bus.zrd_n = 1'b1;
        bus.zwr_n = 1'b1;
        for (int i = 0; i < NP; i++) user_rd[i] = 8'($urandom);
        for (int i = 0; i < NW; i++) mwin[i] = '0;
        repeat (2) @(negedge fclk);
        chk("rst_stb", bus.port_wr_stb, 0);
        chk("rst_port_addr", bus.port_addr, 0);
        chk("rst_wrdata", bus.port_wrdata, 0);
        chk("rst_zd_oe", bus.zd_oe, 0);
        chk("rst_win_cs_n", bus.win_cs_n, 2'b11);
        @(posedge fclk);
        #2 rst = 1'b0;
        repeat (6) @(negedge fclk);
        live = 1'b1;

        io_out(16'h82AB, 8'h5A);
        chk("lit_stb_count", stb_cnt, 1);
        chk("lit_port_addr", stb_addr, 2);
        chk("lit_wrdata", stb_data, 8'h5A);

        user_rd[1] = 8'h3C;
        io_in(16'h81AB, oe, d);
        chk("lit_rd_oe", oe, 1);
        chk("lit_rd_data", d, 8'h3C);

        io_out(16'hC1AB, 8'h06);
        chk("lit_win_wr_no_stb", stb_cnt, 0);
        mem(16'h8000, 1'b0, cs, blk);
        chk("lit_win1_cs", cs, 2'b01);
        chk("lit_win1_blk", blk, 1);
`ifdef ZBUS_READBACK_EN
        io_in(16'hC1AB, oe, d);
        chk("lit_readback", d, 8'h06);
`else
        io_in(16'hC1AB, oe, d);
        chk("lit_no_readback", oe, 0);
`endif

        io_out(16'hC0AB, 8'h06);
        mem(16'h8000, 1'b1, cs, blk);
        chk("lit_prio_cs", cs, 2'b10);

        bus.za = 16'h82AC;
        @(negedge fclk);
        chk("lit_ziorqge_miss", ziorqge === 1'b1, 0);
        io_out(16'h82AC, 8'h11);
        chk("lit_bad_base_no_stb", stb_cnt, 0);
        io_out(16'h85AB, 8'h22);
        chk("lit_bad_index_no_stb", stb_cnt, 0);

        bus.za = 16'h81AB;
        bus.zd_in = 8'h77;
        stb_cnt = 0;
        gap_edge();
        bus.ziorq_n = 1'b0;
        bus.zwr_n = 1'b0;
        #1 rst = 1'b1;
        for (int i = 0; i < NW; i++) mwin[i] = '0;
        @(posedge fclk);
        #2 rst = 1'b0;
        repeat (10) @(negedge fclk);
        gap_edge();
        bus.zwr_n = 1'b1;
        bus.ziorq_n = 1'b1;
        repeat (6) @(negedge fclk);
        chk("lit_rst_no_stb", stb_cnt, 0);
        mem(16'h8000, 1'b0, cs, blk);
        chk("lit_rst_win_off", cs, 2'b11);
        io_out(16'h83AB, 8'h99);
        chk("lit_post_rst_stb", stb_cnt, 1);
        chk("lit_post_rst_addr", stb_addr, 3);

        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 6);
            a[15:14] = 2'($urandom_range(2, 3));
            a[13:8] = 6'($urandom_range(0, 7));
            a[7:0] = $urandom_range(0, 3) == 0 ? 8'($urandom) : BASE;
            case (k)
                0, 1: io_out(a, 8'($urandom));
                2: io_in(a, oe, d);
                3: mem({2'($urandom), 14'($urandom)}, 1'b0, cs, blk);
                4: mem({2'($urandom), 14'($urandom)}, 1'b1, cs, blk);
                5: mem(a, 1'b1, cs, blk);
                default: m1_cycle();
            endcase
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
